// File: rtl/urv_dm_ahb_bridge.sv
// urv_dm_ahb_bridge: turns uRV data-memory requests into single AHB-Lite
// master transfers, one outstanding at a time. Completion, load data and
// bus errors go back to the core as one-cycle done/error pulses.
module urv_dm_ahb_bridge #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    // uRV data-memory port
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_bus_err_o,
    // AHB-Lite master
    output logic [31:0] HADDR_O,
    output logic [1:0]  HTRANS_O,
    output logic [2:0]  HSIZE_O,
    output logic        HWRITE_O,
    output logic [31:0] HWDATA_O,
    output logic [2:0]  HBURST_O,
    output logic [3:0]  HPROT_O,
    output logic        HMASTLOCK_O,
    input  logic [31:0] HRDATA_I,
    input  logic        HREADY_I,
    input  logic        HRESP_I
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    // Lane enables -> {HSIZE, HADDR[1:0]}; unrecognised patterns fall back to a word access.
    function automatic logic [4:0] lane_decode(input logic [3:0] sel);
        logic [4:0] r;
        case (sel)
            4'b1111: r = {HSIZE_WORD, 2'b00};
            4'b0011: r = {HSIZE_HALF, 2'b00};
            4'b1100: r = {HSIZE_HALF, 2'b10};
            4'b0001: r = {HSIZE_BYTE, 2'b00};
            4'b0010: r = {HSIZE_BYTE, 2'b01};
            4'b0100: r = {HSIZE_BYTE, 2'b10};
            4'b1000: r = {HSIZE_BYTE, 2'b11};
            default: r = {HSIZE_WORD, 2'b00};
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic [2:0]  hsize_q, hsize_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] data_l_q, data_l_d;
    logic        load_done_q, load_done_d;
    logic        store_done_q, store_done_d;
    logic        bus_err_q, bus_err_d;

    logic        accept;
    logic        complete;
    logic [4:0]  dec;
    logic        addr_lo_unused;

    // The core supplies byte addresses; the low bits come from the lane decode instead.
    assign addr_lo_unused = ^dm_addr_i[1:0];

    // Next-state and next-output computation; every output is taken from a flop.
    always_comb begin
        accept   = (state_q == ST_IDLE) && (dm_store_i || dm_load_i);
        complete = (state_q == ST_DATA) && HREADY_I;
        dec      = lane_decode(dm_data_select_i);

        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)   state_d = ST_ADDR;
            ST_ADDR: if (HREADY_I) state_d = ST_DATA;
            ST_DATA: if (HREADY_I) state_d = ST_RESP;
            default:               state_d = ST_IDLE;
        endcase

        // Store has priority when both strobes are raised; the load is dropped.
        write_d = accept ? dm_store_i  : write_q;
        wdata_d = accept ? dm_data_s_i : wdata_q;

        ready_d  = (state_d == ST_IDLE);
        htrans_d = (state_d == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;

        // Address-phase signals are loaded on acceptance and held through address wait states.
        if (accept) begin
            haddr_d  = {dm_addr_i[31:2], dec[1:0]};
            hsize_d  = dec[4:2];
            hwrite_d = dm_store_i;
        end else if ((state_q == ST_ADDR) && !HREADY_I) begin
            haddr_d  = haddr_q;
            hsize_d  = hsize_q;
            hwrite_d = hwrite_q;
        end else begin
            haddr_d  = RESET_ADDR;
            hsize_d  = HSIZE_WORD;
            hwrite_d = 1'b0;
        end

        hwdata_d = ((state_d == ST_DATA) && write_q) ? wdata_q : hwdata_q;

        load_done_d  = complete && !write_q;
        store_done_d = complete && write_q;
        bus_err_d    = complete && HRESP_I;

        data_l_d = data_l_q;
        if (complete && !write_q) begin
            data_l_d = HRESP_I ? 32'h0 : HRDATA_I;
        end
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b1;
            write_q      <= 1'b0;
            wdata_q      <= 32'h0;
            htrans_q     <= HTRANS_IDLE;
            haddr_q      <= RESET_ADDR;
            hsize_q      <= HSIZE_WORD;
            hwrite_q     <= 1'b0;
            hwdata_q     <= 32'h0;
            data_l_q     <= 32'h0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            htrans_q     <= htrans_d;
            haddr_q      <= haddr_d;
            hsize_q      <= hsize_d;
            hwrite_q     <= hwrite_d;
            hwdata_q     <= hwdata_d;
            data_l_q     <= data_l_d;
            load_done_q  <= load_done_d;
            store_done_q <= store_done_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign dm_ready_o      = ready_q;
    assign dm_data_l_o     = data_l_q;
    assign dm_load_done_o  = load_done_q;
    assign dm_store_done_o = store_done_q;
    assign dm_bus_err_o    = bus_err_q;

    assign HADDR_O     = haddr_q;
    assign HTRANS_O    = htrans_q;
    assign HSIZE_O     = hsize_q;
    assign HWRITE_O    = hwrite_q;
    assign HWDATA_O    = hwdata_q;
    assign HBURST_O    = 3'b000;
    assign HPROT_O     = HPROT_VAL;
    assign HMASTLOCK_O = 1'b0;

endmodule

// File: tb/tb_urv_dm_ahb_bridge.sv
// Directed testbench for urv_dm_ahb_bridge; the bench plays the AHB slave.
module tb_urv_dm_ahb_bridge;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_store_i;
    logic        dm_load_i;
    logic        dm_ready_o;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        dm_store_done_o;
    logic        dm_bus_err_o;
    logic [31:0] HADDR_O;
    logic [1:0]  HTRANS_O;
    logic [2:0]  HSIZE_O;
    logic        HWRITE_O;
    logic [31:0] HWDATA_O;
    logic [2:0]  HBURST_O;
    logic [3:0]  HPROT_O;
    logic        HMASTLOCK_O;
    logic [31:0] HRDATA_I;
    logic        HREADY_I;
    logic        HRESP_I;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mem [0:255];
    logic [31:0] exp_dl;

    urv_dm_ahb_bridge dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .dm_addr_i        (dm_addr_i),
        .dm_data_s_i      (dm_data_s_i),
        .dm_data_select_i (dm_data_select_i),
        .dm_store_i       (dm_store_i),
        .dm_load_i        (dm_load_i),
        .dm_ready_o       (dm_ready_o),
        .dm_data_l_o      (dm_data_l_o),
        .dm_load_done_o   (dm_load_done_o),
        .dm_store_done_o  (dm_store_done_o),
        .dm_bus_err_o     (dm_bus_err_o),
        .HADDR_O          (HADDR_O),
        .HTRANS_O         (HTRANS_O),
        .HSIZE_O          (HSIZE_O),
        .HWRITE_O         (HWRITE_O),
        .HWDATA_O         (HWDATA_O),
        .HBURST_O         (HBURST_O),
        .HPROT_O          (HPROT_O),
        .HMASTLOCK_O      (HMASTLOCK_O),
        .HRDATA_I         (HRDATA_I),
        .HREADY_I         (HREADY_I),
        .HRESP_I          (HRESP_I)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One complete transfer with aw address-phase and dw data-phase wait states.
    task automatic xfer(input string tag, input logic st, input logic ld,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] sel,
                        input int aw, input int dw, input logic err,
                        input logic [31:0] exp_haddr, input logic [2:0] exp_hsize);
        logic [7:0] idx;
        idx = exp_haddr[9:2];
        check({tag, "/ready_idle"}, dm_ready_o, 1'b1);
        dm_store_i = st; dm_load_i = ld; dm_addr_i = addr;
        dm_data_s_i = wd; dm_data_select_i = sel;
        HREADY_I = 1'b1; HRESP_I = 1'b0;
        tick();
        dm_store_i = 1'b0; dm_load_i = 1'b0;
        check({tag, "/htrans_a"}, HTRANS_O, 2'b10);
        check({tag, "/haddr"}, HADDR_O, exp_haddr);
        check({tag, "/hsize"}, HSIZE_O, exp_hsize);
        check({tag, "/hwrite"}, HWRITE_O, st);
        check({tag, "/ready_busy"}, dm_ready_o, 1'b0);
        for (int i = 0; i < aw; i++) begin
            HREADY_I = 1'b0;
            tick();
            check({tag, "/htrans_aw"}, HTRANS_O, 2'b10);
            check({tag, "/haddr_aw"}, HADDR_O, exp_haddr);
        end
        HREADY_I = 1'b1;
        tick();
        check({tag, "/htrans_d"}, HTRANS_O, 2'b00);
        if (st) check({tag, "/hwdata"}, HWDATA_O, wd);
        for (int i = 0; i < dw; i++) begin
            HREADY_I = 1'b0; HRESP_I = err;
            tick();
            check({tag, "/done_early"}, {dm_load_done_o, dm_store_done_o}, 2'b00);
        end
        HREADY_I = 1'b1; HRESP_I = err; HRDATA_I = mem[idx];
        tick();
        if (st) begin
            mem[idx] = wd;
        end else begin
            exp_dl = err ? 32'h0 : mem[idx];
        end
        check({tag, "/store_done"}, dm_store_done_o, st);
        check({tag, "/load_done"}, dm_load_done_o, !st);
        check({tag, "/bus_err"}, dm_bus_err_o, err);
        check({tag, "/data_l"}, dm_data_l_o, exp_dl);
        check({tag, "/ready_resp"}, dm_ready_o, 1'b0);
        HRESP_I = 1'b0; HRDATA_I = 32'h0;
        tick();
        check({tag, "/ready_after"}, dm_ready_o, 1'b1);
        check({tag, "/pulse_end"}, {dm_load_done_o, dm_store_done_o, dm_bus_err_o}, 3'b000);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        exp_dl = 32'h0;
        rst_n_i = 1'b0;
        dm_addr_i = 32'h0; dm_data_s_i = 32'h0; dm_data_select_i = 4'h0;
        dm_store_i = 1'b0; dm_load_i = 1'b0;
        HRDATA_I = 32'h0; HREADY_I = 1'b1; HRESP_I = 1'b0;
        repeat (3) tick();
        rst_n_i = 1'b1;
        tick();

        // reset values
        check("rst/ready", dm_ready_o, 1'b1);
        check("rst/htrans", HTRANS_O, 2'b00);
        check("rst/haddr", HADDR_O, 32'h0);
        check("rst/hsize", HSIZE_O, 3'b010);
        check("rst/hwrite", HWRITE_O, 1'b0);
        check("rst/hwdata", HWDATA_O, 32'h0);
        check("rst/data_l", dm_data_l_o, 32'h0);
        check("rst/pulses", {dm_load_done_o, dm_store_done_o, dm_bus_err_o}, 3'b000);
        check("rst/hburst", HBURST_O, 3'b000);
        check("rst/hprot", HPROT_O, 4'b0011);
        check("rst/hmastlock", HMASTLOCK_O, 1'b0);

        // word store then readback
        xfer("st_word", 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'b1111, 0, 0, 1'b0, 32'h100, 3'd2);
        xfer("ld_back", 1'b0, 1'b1, 32'h100, 32'h0, 4'b1111, 0, 0, 1'b0, 32'h100, 3'd2);

        // lane decode
        xfer("dec_b2",  1'b0, 1'b1, 32'h203, 32'h0, 4'b0100, 0, 0, 1'b0, 32'h202, 3'd0);
        xfer("dec_h1",  1'b0, 1'b1, 32'h200, 32'h0, 4'b1100, 0, 0, 1'b0, 32'h202, 3'd1);
        xfer("dec_odd", 1'b0, 1'b1, 32'h200, 32'h0, 4'b0101, 0, 0, 1'b0, 32'h200, 3'd2);
        xfer("dec_b3",  1'b0, 1'b1, 32'h200, 32'h0, 4'b1000, 0, 0, 1'b0, 32'h203, 3'd0);
        xfer("dec_h0",  1'b0, 1'b1, 32'h202, 32'h0, 4'b0011, 0, 0, 1'b0, 32'h200, 3'd1);
        xfer("dec_b1",  1'b0, 1'b1, 32'h200, 32'h0, 4'b0010, 0, 0, 1'b0, 32'h201, 3'd0);
        xfer("dec_none", 1'b0, 1'b1, 32'h201, 32'h0, 4'b0000, 0, 0, 1'b0, 32'h200, 3'd2);

        // wait states: 2 address, 3 data -> done at cycle 8
        mem[8'hC0] = 32'h12345678;
        xfer("wait", 1'b0, 1'b1, 32'h300, 32'h0, 4'b1111, 2, 3, 1'b0, 32'h300, 3'd2);

        // error response on a load
        xfer("err_ld", 1'b0, 1'b1, 32'h100, 32'h0, 4'b1111, 0, 1, 1'b1, 32'h100, 3'd2);

        // store wins over simultaneous load
        xfer("st_wins", 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'b1111, 0, 0, 1'b0, 32'h40, 3'd2);

        // reset during the data phase
        dm_store_i = 1'b1; dm_addr_i = 32'h80; dm_data_s_i = 32'h55AA55AA;
        dm_data_select_i = 4'b1111;
        tick();
        dm_store_i = 1'b0;
        check("rstmid/htrans_a", HTRANS_O, 2'b10);
        tick();
        check("rstmid/hwdata", HWDATA_O, 32'h55AA55AA);
        HREADY_I = 1'b0;
        rst_n_i = 1'b0;
        #1;
        check("rstmid/htrans", HTRANS_O, 2'b00);
        check("rstmid/ready", dm_ready_o, 1'b1);
        check("rstmid/hwdata0", HWDATA_O, 32'h0);
        tick();
        rst_n_i = 1'b1;
        HREADY_I = 1'b1;
        exp_dl = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rstmid/no_done", {dm_load_done_o, dm_store_done_o, dm_bus_err_o}, 3'b000);
        end
        xfer("after_rst", 1'b0, 1'b1, 32'h100, 32'h0, 4'b1111, 0, 0, 1'b0, 32'h100, 3'd2);
        check("after_rst/value", dm_data_l_o, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/urv_dm_ahb_bridge.md
# urv_dm_ahb_bridge

Converts the uRV core's native data-memory port (dm_addr/dm_data_s/dm_data_select/dm_store/dm_load, with load/store done and ready handshakes) into single AHB-Lite master transfers. It sits between the urv_cpu data port and the AHB data fabric, alongside the instruction fetch master that already drives cmsdk_ahb_ram_beh. Exactly one transfer is outstanding at a time. Completion, read data and bus errors are returned to the core through the done strobes.

## Interface
- RESET_ADDR, 32'h0000_0000: HADDR value driven while idle and after reset.
- HPROT_VAL, 4'b0011: constant HPROT value (data access, privileged).
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_n_i  in  1  reset, asynchronous and active-low.
- dm_addr_i  in  32  byte address from core; bits [1:0] are ignored.
- dm_data_s_i  in  32  store data, already lane-aligned by the core.
- dm_data_select_i  in  4  byte-lane enables.
- dm_store_i / dm_load_i  in  1 each  request strobes, held by the core until accepted.
- dm_ready_o  out  1  bridge can accept a request this cycle.
- dm_data_l_o  out  32  load data; full HRDATA word, no lane extraction.
- dm_load_done_o / dm_store_done_o  out  1 each  one-cycle completion pulses.
- dm_bus_err_o  out  1  one-cycle pulse, coincident with the done pulse, when the slave returned ERROR.
- HADDR_O 32, HTRANS_O 2, HSIZE_O 3, HWRITE_O 1, HWDATA_O 32, HBURST_O 3, HPROT_O 4, HMASTLOCK_O 1  out  AHB-Lite master outputs.
- HRDATA_I 32, HREADY_I 1, HRESP_I 1  in  AHB-Lite master inputs.

## Operation
- FSM states:
  - IDLE: dm_ready_o=1.
  - ADDR: HTRANS_O=NONSEQ (2'b10).
  - DATA: HTRANS_O=IDLE.
  - RESP: done pulse.
- IDLE -> ADDR when (dm_store_i|dm_load_i) is high in a cycle with dm_ready_o=1.
  - On acceptance, register address, data, lanes and direction.
  - If dm_store_i and dm_load_i are both high, the store wins and the load is dropped; the core must re-issue the load.
- ADDR -> DATA on HREADY_I=1. Hold all address-phase signals while HREADY_I=0.
- DATA -> RESP on HREADY_I=1.
  - Capture HRDATA_I into dm_data_l_o for a load.
  - Capture (HRESP_I==1) into an error flag.
- RESP -> IDLE unconditionally.
  - Pulse dm_load_done_o or dm_store_done_o.
  - Pulse dm_bus_err_o if the error flag is set.
  - For an erroring load, dm_data_l_o=0.
- Lane decode to HSIZE_O and HADDR_O[1:0]:
  - 1111 -> word, 00.
  - 0011 -> half, 00.
  - 1100 -> half, 10.
  - 0001/0010/0100/1000 -> byte, 00/01/10/11.
  - Any other pattern, including 0000 -> word, 00. This is defined behaviour and not flagged.
- HADDR_O[31:2] = dm_addr_i[31:2].
- HWDATA_O is driven from the registered store data during DATA only, and held at its value otherwise.
- HWRITE_O=1 during ADDR for stores.
- Constant outputs: HBURST_O=3'b000 (SINGLE), HPROT_O=HPROT_VAL, HMASTLOCK_O=0.
- ERROR response (HRESP_I=1 with HREADY_I=0): the bridge stays in DATA and completes on the following HREADY_I=1. No retry.
- dm_data_l_o holds its last value until the next load completes.

## Timing
- Reset (async assert, sync release) values:
  - state=IDLE, dm_ready_o=1.
  - done, err pulses=0; dm_data_l_o=0.
  - HTRANS_O=IDLE, HADDR_O=RESET_ADDR, HSIZE_O=3'b010, HWRITE_O=0, HWDATA_O=0.
- Reset asserted mid-transfer: HTRANS_O goes to IDLE immediately. No done pulse is produced for the abandoned request.
- Zero-wait slave:
  - request accepted at edge 0;
  - NONSEQ visible cycle 1;
  - data phase cycle 2;
  - done pulse cycle 3;
  - dm_ready_o high again cycle 4.
- Total latency is 3 + (address wait states) + (data wait states).
- dm_ready_o is low from the cycle after acceptance through RESP. Back-to-back throughput is one transfer per 4 cycles.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Word store, zero-wait: addr 0x100, data 0xDEADBEEF, sel 1111 -> cycle 1 HADDR_O=0x100, HSIZE_O=2, HWRITE_O=1, NONSEQ; cycle 2 HWDATA_O=0xDEADBEEF; cycle 3 dm_store_done_o=1; readback via load returns 0xDEADBEEF.
- Byte and half decode: sel 0100 at 0x203 -> HADDR_O=0x202, HSIZE_O=0. Sel 1100 at 0x200 -> HADDR_O=0x202, HSIZE_O=1. Sel 0101 -> HSIZE_O=2, HADDR_O=0x200.
- Wait states: HREADY_I low 2 cycles in the address phase and 3 in the data phase -> NONSEQ and HADDR_O held stable; dm_load_done_o arrives at cycle 8 with HRDATA_I=0x12345678 on dm_data_l_o.
- Error: slave returns ERROR on a load -> dm_load_done_o and dm_bus_err_o pulse together; dm_data_l_o=0; dm_ready_o=1 the next cycle.
- Simultaneous store and load strobes at 0x40 -> a single write transfer is issued; only dm_store_done_o pulses.
- rst_n_i low during DATA -> HTRANS_O=IDLE within the same cycle; no done pulse; a fresh request after release completes normally.
